// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial sequence detector with registered Mealy match
// output, overlap/non-overlap selection and a saturating match counter.
module seq_detect_prog #(
  parameter int unsigned          MAX_LEN     = 8,
  parameter int unsigned          CNT_W       = 8,
  parameter logic [MAX_LEN-1:0]   DEF_PATTERN = MAX_LEN'(9),
  parameter int unsigned          DEF_LEN     = 4,
  parameter bit                   DEF_OVERLAP = 1'b1,
  localparam int unsigned         LW          = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               ser_in,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  typedef enum logic {
    S_FILL  = 1'b0,
    S_ARMED = 1'b1
  } state_t;

  logic [MAX_LEN-1:0] pattern_q, pattern_nxt;
  logic [LW-1:0]      len_q, len_nxt;
  logic               overlap_q, overlap_nxt;
  logic [MAX_LEN-1:0] hist_q, hist_nxt;
  logic [LW-1:0]      fill_q, fill_nxt;
  logic               match_nxt;
  logic [CNT_W-1:0]   count_nxt;
  logic               cfg_err_nxt;

  state_t             state_c;
  logic [MAX_LEN-1:0] len_mask_c;
  logic [MAX_LEN-1:0] load_mask_c;
  logic [MAX_LEN-1:0] win_c;
  logic               cfg_legal_c;
  logic               hit_c;

  // Masks selecting the low len bits for the active and the incoming length
  always_comb begin
    len_mask_c  = '0;
    load_mask_c = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      len_mask_c[i]  = (LW'(i) < len_q);
      load_mask_c[i] = (LW'(i) < cfg_len);
    end
  end

  // State register: configuration, history, fill and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q   <= DEF_PATTERN;
      len_q       <= LW'(DEF_LEN);
      overlap_q   <= DEF_OVERLAP;
      hist_q      <= '0;
      fill_q      <= '0;
      match       <= 1'b0;
      match_count <= '0;
      cfg_err     <= 1'b0;
    end else begin
      pattern_q   <= pattern_nxt;
      len_q       <= len_nxt;
      overlap_q   <= overlap_nxt;
      hist_q      <= hist_nxt;
      fill_q      <= fill_nxt;
      match       <= match_nxt;
      match_count <= count_nxt;
      cfg_err     <= cfg_err_nxt;
    end
  end

  // Next-state logic: legal load wins over a valid bit; illegal load only flags
  always_comb begin
    pattern_nxt = pattern_q;
    len_nxt     = len_q;
    overlap_nxt = overlap_q;
    hist_nxt    = hist_q;
    fill_nxt    = fill_q;
    match_nxt   = 1'b0;
    count_nxt   = match_count;
    cfg_err_nxt = 1'b0;

    cfg_legal_c = (cfg_len != '0) && (cfg_len <= LW'(MAX_LEN));
    win_c       = {hist_q[MAX_LEN-2:0], ser_in};
    state_c     = (fill_q >= (len_q - LW'(1))) ? S_ARMED : S_FILL;
    hit_c       = in_valid && (state_c == S_ARMED) &&
                  ((win_c & len_mask_c) == (pattern_q & len_mask_c));

    if (cfg_load && cfg_legal_c) begin
      pattern_nxt = cfg_pattern & load_mask_c;
      len_nxt     = cfg_len;
      overlap_nxt = cfg_overlap;
      hist_nxt    = '0;
      fill_nxt    = '0;
      count_nxt   = '0;
    end else begin
      cfg_err_nxt = cfg_load;
      if (in_valid) begin
        hist_nxt  = win_c;
        match_nxt = hit_c;
        if (hit_c && (match_count != '1)) begin
          count_nxt = match_count + CNT_W'(1);
        end
        if (hit_c && !overlap_q) begin
          fill_nxt = '0;
        end else if (fill_q != LW'(MAX_LEN)) begin
          fill_nxt = fill_q + LW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: directed scenarios plus random traffic checked
// against a queue-based model of the valid bits seen since the last clear.
module tb_seq_detect_prog;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LW      = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LW-1:0]      cfg_len;
  logic               cfg_overlap;
  logic               in_valid;
  logic               ser_in;
  logic               match,   match_s;
  logic [7:0]         match_count;
  logic [1:0]         match_count_s;
  logic               cfg_err, cfg_err_s;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ov;
  bit         q[$];
  bit         e_match, e_err;
  int         e_cnt, e_cnt_s;

  seq_detect_prog #(.MAX_LEN(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .ser_in(ser_in), .match(match), .match_count(match_count), .cfg_err(cfg_err)
  );

  seq_detect_prog #(.MAX_LEN(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .ser_in(ser_in), .match(match_s), .match_count(match_count_s), .cfg_err(cfg_err_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the specification's rules
  task automatic model_step(input bit r, input bit l, input logic [7:0] p,
                            input logic [3:0] len, input bit ov, input bit v, input bit b);
    int  w;
    bit  hit;
    if (r) begin
      m_pat = 8'h09; m_len = 4; m_ov = 1'b1; q.delete();
      e_match = 0; e_err = 0; e_cnt = 0; e_cnt_s = 0;
    end else if (l && len >= 1 && len <= 8) begin
      m_pat = p; m_len = int'(len); m_ov = ov; q.delete();
      e_match = 0; e_err = 0; e_cnt = 0; e_cnt_s = 0;
    end else begin
      e_err   = l;
      e_match = 0;
      if (v) begin
        q.push_back(b);
        if (q.size() > int'(MAX_LEN)) void'(q.pop_front());
        hit = 0;
        if (q.size() >= m_len) begin
          w = 0;
          for (int i = 0; i < m_len; i++) w = (w << 1) | int'(q[q.size() - m_len + i]);
          hit = (w == (int'(m_pat) & ((1 << m_len) - 1)));
        end
        if (hit) begin
          e_match = 1;
          if (e_cnt < 255) e_cnt++;
          if (e_cnt_s < 3) e_cnt_s++;
          if (!m_ov) q.delete();
        end
      end
    end
  endtask

  task automatic cycle(input bit r, input bit l, input logic [7:0] p,
                       input logic [3:0] len, input bit ov, input bit v, input bit b);
    rst = r; cfg_load = l; cfg_pattern = p; cfg_len = len;
    cfg_overlap = ov; in_valid = v; ser_in = b;
    model_step(r, l, p, len, ov, v, b);
    @(posedge clk);
    #1;
    chk("match",         32'(match),         32'(e_match));
    chk("match_count",   32'(match_count),   32'(e_cnt));
    chk("cfg_err",       32'(cfg_err),       32'(e_err));
    chk("match_sat",     32'(match_s),       32'(e_match));
    chk("match_cnt_sat", 32'(match_count_s), 32'(e_cnt_s));
    chk("cfg_err_sat",   32'(cfg_err_s),     32'(e_err));
  endtask

  task automatic do_rst();
    cycle(1, 0, 8'h00, 4'd0, 0, 0, 0);
  endtask
  task automatic bitc(input bit b);
    cycle(0, 0, 8'h00, 4'd0, 0, 1, b);
  endtask
  task automatic idle();
    cycle(0, 0, 8'h00, 4'd0, 0, 0, 0);
  endtask
  task automatic load(input logic [7:0] p, input logic [3:0] len, input bit ov);
    cycle(0, 1, p, len, ov, 0, 0);
  endtask

  initial begin
    logic [9:0] s10;
    logic [3:0] s4;
    int         pulses;

    // Reset state
    do_rst();
    do_rst();
    chk("rst_count", 32'(match_count), 32'd0);

    // Default 1001 overlapping: matches after bits 4, 7, 10
    s10 = 10'b1001001001;
    for (int i = 9; i >= 0; i--) bitc(s10[i]);
    chk("t1_count", 32'(match_count), 32'd3);

    // Non-overlapping 1001: matches after bits 4 and 10
    load(8'h09, 4'd4, 1'b0);
    for (int i = 9; i >= 0; i--) bitc(s10[i]);
    chk("t2_count", 32'(match_count), 32'd2);

    // Gaps between valid bits do not break the sequence
    do_rst();
    s4 = 4'b1001;
    pulses = 0;
    for (int i = 3; i >= 0; i--) begin
      bitc(s4[i]);
      if (match === 1'b1) pulses++;
      for (int g = 0; g < 3; g++) begin
        idle();
        if (match === 1'b1) pulses++;
      end
    end
    chk("t3_pulses", 32'(pulses), 32'd1);

    // Reset mid-sequence discards progress
    do_rst();
    bitc(1); bitc(0); bitc(0);
    do_rst();
    bitc(1);
    chk("t4_nomatch", 32'(match), 32'd0);
    bitc(0); bitc(0); bitc(1);
    bitc(1); bitc(0); bitc(0); bitc(1);
    chk("t4_final", 32'(match), 32'd1);

    // Illegal lengths flag cfg_err and keep the old pattern
    do_rst();
    load(8'hFF, 4'd0, 1'b1);
    chk("t5_err0", 32'(cfg_err), 32'd1);
    idle();
    chk("t5_err0_clr", 32'(cfg_err), 32'd0);
    bitc(1); bitc(0); bitc(0); bitc(1);
    chk("t5_old_pat", 32'(match), 32'd1);
    load(8'hFF, 4'd9, 1'b1);
    chk("t5_err9", 32'(cfg_err), 32'd1);
    bitc(0); bitc(0); bitc(1);
    chk("t5_old_pat9", 32'(match), 32'd1);

    // len = 1: every 1 hits; 2-bit counter saturates at 3
    load(8'h01, 4'd1, 1'b1);
    for (int i = 0; i < 6; i++) bitc(1);
    chk("t6_cnt_sat", 32'(match_count_s), 32'd3);
    chk("t6_cnt_full", 32'(match_count), 32'd6);
    load(8'h01, 4'd1, 1'b0);
    chk("t6_cnt_clr", 32'(match_count_s), 32'd0);
    for (int i = 0; i < 6; i++) bitc(1);
    chk("t6_nonov", 32'(match_count), 32'd6);

    // Legal load with a valid bit in the same cycle drops the bit
    cycle(0, 1, 8'h03, 4'd2, 1'b1, 1, 1);
    bitc(1);
    chk("load_drop", 32'(match), 32'd0);
    bitc(1);
    chk("load_drop_hit", 32'(match), 32'd1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      bit         r, l, ov, v, b;
      logic [7:0] p;
      logic [3:0] len;
      r   = ($urandom_range(0, 99) == 0);
      l   = ($urandom_range(0, 24) == 0);
      p   = 8'($urandom);
      len = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                        : 4'($urandom_range(1, 4));
      ov  = 1'($urandom);
      v   = ($urandom_range(0, 3) != 0);
      b   = 1'($urandom);
      cycle(r, l, p, len, ov, v, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
